// File: rtl/obi_credit_adapter_if.sv
// OBI 1.x A/R channel bundle between a host adapter (master) and a memory-side agent (slave).
interface obi_credit_adapter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ATOP_WIDTH = 6
);
  logic                      req;
  logic                      gnt;
  logic [ADDR_WIDTH-1:0]     addr;
  logic                      we;
  logic [DATA_WIDTH/8-1:0]   be;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [ATOP_WIDTH-1:0]     atop;
  logic [DATA_WIDTH-1:0]     rdata;
  logic                      rvalid;
  logic                      err;

  modport master (
    output req, addr, we, be, wdata, atop,
    input  gnt, rdata, rvalid, err
  );

  modport slave (
    input  req, addr, we, be, wdata, atop,
    output gnt, rdata, rvalid, err
  );
endinterface

// File: rtl/obi_credit_adapter.sv
// OBI host adapter: credit-limited A-channel (held stable until grant), zero-latency
// fall-through response FIFO so resp_ready_i back-pressure never drops a response.
module obi_credit_adapter #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ATOP_WIDTH      = 6,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter bit          TRANS_STABLE    = 1'b0,
  localparam int unsigned BE_WIDTH       = DATA_WIDTH / 8,
  localparam int unsigned CNT_WIDTH      = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  trans_valid_i,
  output logic                  trans_ready_o,
  input  logic [ADDR_WIDTH-1:0] trans_addr_i,
  input  logic                  trans_we_i,
  input  logic [BE_WIDTH-1:0]   trans_be_i,
  input  logic [DATA_WIDTH-1:0] trans_wdata_i,
  input  logic [ATOP_WIDTH-1:0] trans_atop_i,

  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o,

  obi_credit_adapter_if.master  obi,

  output logic [CNT_WIDTH-1:0]  outstanding_o,
  output logic                  idle_o
);

  localparam int unsigned PTR_WIDTH = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(MAX_OUTSTANDING - 1);

  typedef struct packed {
    logic                  err;
    logic [DATA_WIDTH-1:0] rdata;
  } resp_t;

  logic                  obi_req;
  logic [ADDR_WIDTH-1:0] obi_addr;
  logic                  obi_we;
  logic [BE_WIDTH-1:0]   obi_be;
  logic [DATA_WIDTH-1:0] obi_wdata;
  logic [ATOP_WIDTH-1:0] obi_atop;
  logic                  transparent;

  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  credit_ok;
  logic                  grant;
  logic                  pop;

  assign credit_ok = (cnt_q < CNT_MAX);
  assign grant     = obi_req & obi.gnt;
  assign pop       = resp_valid_o & resp_ready_i;

  always_comb begin
    cnt_d = cnt_q;
    case ({grant, pop})
      2'b10:   cnt_d = cnt_q + CNT_WIDTH'(1);
      2'b01:   cnt_d = cnt_q - CNT_WIDTH'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // ---------------------------------------------------------------- A-channel
  if (!TRANS_STABLE) begin : g_fsm
    typedef enum logic {TRANSPARENT, REGISTERED} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [BE_WIDTH-1:0]   be_q, be_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ATOP_WIDTH-1:0] atop_q, atop_d;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= TRANSPARENT;
        addr_q  <= '0;
        we_q    <= 1'b0;
        be_q    <= '0;
        wdata_q <= '0;
        atop_q  <= '0;
      end else begin
        state_q <= state_d;
        addr_q  <= addr_d;
        we_q    <= we_d;
        be_q    <= be_d;
        wdata_q <= wdata_d;
        atop_q  <= atop_d;
      end
    end

    always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      we_d          = we_q;
      be_d          = be_q;
      wdata_d       = wdata_q;
      atop_d        = atop_q;
      obi_req       = 1'b0;
      obi_addr      = trans_addr_i;
      obi_we        = trans_we_i;
      obi_be        = trans_be_i;
      obi_wdata     = trans_wdata_i;
      obi_atop      = trans_atop_i;
      trans_ready_o = 1'b0;
      unique case (state_q)
        TRANSPARENT: begin
          obi_req       = trans_valid_i & credit_ok;
          trans_ready_o = credit_ok;
          // The upstream may move on once accepted, so an ungranted request is latched.
          if (obi_req && !obi.gnt) begin
            state_d = REGISTERED;
            addr_d  = trans_addr_i;
            we_d    = trans_we_i;
            be_d    = trans_be_i;
            wdata_d = trans_wdata_i;
            atop_d  = trans_atop_i;
          end
        end
        REGISTERED: begin
          obi_req   = 1'b1;
          obi_addr  = addr_q;
          obi_we    = we_q;
          obi_be    = be_q;
          obi_wdata = wdata_q;
          obi_atop  = atop_q;
          if (obi.gnt) begin
            state_d = TRANSPARENT;
          end
        end
        default: begin
          state_d = TRANSPARENT;
        end
      endcase
    end

    assign transparent = (state_q == TRANSPARENT);
  end else begin : g_pass
    assign obi_req       = trans_valid_i & credit_ok;
    assign obi_addr      = trans_addr_i;
    assign obi_we        = trans_we_i;
    assign obi_be        = trans_be_i;
    assign obi_wdata     = trans_wdata_i;
    assign obi_atop      = trans_atop_i;
    assign trans_ready_o = obi.gnt & credit_ok;
    assign transparent   = 1'b1;
  end

  assign obi.req   = obi_req;
  assign obi.addr  = obi_addr;
  assign obi.we    = obi_we;
  assign obi.be    = obi_be;
  assign obi.wdata = obi_wdata;
  assign obi.atop  = obi_atop;

  // ---------------------------------------------------------------- R-channel
  resp_t                 mem_q [MAX_OUTSTANDING];
  logic [PTR_WIDTH-1:0]  rptr_q, wptr_q;
  logic [CNT_WIDTH-1:0]  fcnt_q;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  rsp_ok;
  logic                  fifo_push;
  logic                  fifo_pop;
  resp_t                 rsp_in;
  resp_t                 rsp_out;

  assign fifo_empty = (fcnt_q == '0);
  assign fifo_full  = (fcnt_q == CNT_MAX);
  // A beat with nothing granted is a protocol violation and is dropped.
  assign rsp_ok     = obi.rvalid & ((cnt_q != '0) | grant);
  assign rsp_in     = '{err: obi.err, rdata: obi.rdata};
  assign rsp_out    = fifo_empty ? rsp_in : mem_q[rptr_q];

  assign resp_valid_o = ~fifo_empty | rsp_ok;
  assign resp_rdata_o = rsp_out.rdata;
  assign resp_err_o   = rsp_out.err;

  assign fifo_push = rsp_ok & ~(fifo_empty & resp_ready_i);
  assign fifo_pop  = ~fifo_empty & resp_ready_i;

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      mem_q[wptr_q] <= rsp_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q <= '0;
      wptr_q <= '0;
      fcnt_q <= '0;
    end else begin
      if (fifo_push) begin
        wptr_q <= (wptr_q == PTR_LAST) ? '0 : wptr_q + PTR_WIDTH'(1);
      end
      if (fifo_pop) begin
        rptr_q <= (rptr_q == PTR_LAST) ? '0 : rptr_q + PTR_WIDTH'(1);
      end
      case ({fifo_push, fifo_pop})
        2'b10:   fcnt_q <= fcnt_q + CNT_WIDTH'(1);
        2'b01:   fcnt_q <= fcnt_q - CNT_WIDTH'(1);
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

  assign outstanding_o = cnt_q;
  assign idle_o        = (cnt_q == '0) & transparent;

`ifndef SYNTHESIS
  a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (obi_req && !obi.gnt) |=> ($stable(obi_addr) && $stable(obi_we) && $stable(obi_be)
                               && $stable(obi_wdata) && $stable(obi_atop)));
  a_cnt_bound:   assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= CNT_MAX);
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(fifo_push && fifo_full));
  a_no_stray_r:  assert property (@(posedge clk) disable iff (!rst_n)
    !(obi.rvalid && (cnt_q == '0) && !grant));
`endif

endmodule

// File: tb/tb_obi_credit_adapter.sv
module tb_obi_credit_adapter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Instance A: MAX_OUTSTANDING=2, 32-bit, registered A-channel
  obi_credit_adapter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ATOP_WIDTH(6)) ifa ();
  logic        a_tv, a_tr, a_we, a_rv, a_rr, a_re, a_idle;
  logic [31:0] a_addr, a_wdata, a_rd;
  logic [3:0]  a_be;
  logic [5:0]  a_atop;
  logic [1:0]  a_cnt;

  obi_credit_adapter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ATOP_WIDTH(6),
                       .MAX_OUTSTANDING(2), .TRANS_STABLE(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n),
    .trans_valid_i(a_tv), .trans_ready_o(a_tr), .trans_addr_i(a_addr), .trans_we_i(a_we),
    .trans_be_i(a_be), .trans_wdata_i(a_wdata), .trans_atop_i(a_atop),
    .resp_valid_o(a_rv), .resp_ready_i(a_rr), .resp_rdata_o(a_rd), .resp_err_o(a_re),
    .obi(ifa), .outstanding_o(a_cnt), .idle_o(a_idle));

  // Instance B: single credit, 64-bit data
  obi_credit_adapter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ATOP_WIDTH(6)) ifb ();
  logic        b_tv, b_tr, b_we, b_rv, b_rr, b_re, b_idle;
  logic [31:0] b_addr;
  logic [63:0] b_wdata, b_rd;
  logic [7:0]  b_be;
  logic [5:0]  b_atop;
  logic [0:0]  b_cnt;

  obi_credit_adapter #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ATOP_WIDTH(6),
                       .MAX_OUTSTANDING(1), .TRANS_STABLE(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n),
    .trans_valid_i(b_tv), .trans_ready_o(b_tr), .trans_addr_i(b_addr), .trans_we_i(b_we),
    .trans_be_i(b_be), .trans_wdata_i(b_wdata), .trans_atop_i(b_atop),
    .resp_valid_o(b_rv), .resp_ready_i(b_rr), .resp_rdata_o(b_rd), .resp_err_o(b_re),
    .obi(ifb), .outstanding_o(b_cnt), .idle_o(b_idle));

  // Instance C: stable upstream, no A-channel registers
  obi_credit_adapter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ATOP_WIDTH(6)) ifc ();
  logic        c_tv, c_tr, c_we, c_rv, c_rr, c_re, c_idle;
  logic [31:0] c_addr, c_wdata, c_rd;
  logic [3:0]  c_be;
  logic [5:0]  c_atop;
  logic [1:0]  c_cnt;

  obi_credit_adapter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ATOP_WIDTH(6),
                       .MAX_OUTSTANDING(2), .TRANS_STABLE(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n),
    .trans_valid_i(c_tv), .trans_ready_o(c_tr), .trans_addr_i(c_addr), .trans_we_i(c_we),
    .trans_be_i(c_be), .trans_wdata_i(c_wdata), .trans_atop_i(c_atop),
    .resp_valid_o(c_rv), .resp_ready_i(c_rr), .resp_rdata_o(c_rd), .resp_err_o(c_re),
    .obi(ifc), .outstanding_o(c_cnt), .idle_o(c_idle));

  typedef struct {
    logic        tv;
    logic [31:0] addr;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rerr;
    logic        rrdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_trdy;
    logic        e_rv;
    logic [31:0] e_rdata;
    logic        e_rerr;
    logic [1:0]  e_cnt;
    logic        e_idle;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic [31:0] tv, addr, gnt, rv, rdata, rerr, rrdy,
                              e_req, e_addr, e_trdy, e_rv, e_rdata, e_rerr, e_cnt, e_idle);
    vec_t r;
    r.tv = tv[0];      r.addr = addr;     r.gnt = gnt[0];     r.rv = rv[0];
    r.rdata = rdata;   r.rerr = rerr[0];  r.rrdy = rrdy[0];
    r.e_req = e_req[0]; r.e_addr = e_addr; r.e_trdy = e_trdy[0]; r.e_rv = e_rv[0];
    r.e_rdata = e_rdata; r.e_rerr = e_rerr[0]; r.e_cnt = e_cnt[1:0]; r.e_idle = e_idle[0];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_tv = 0; a_addr = 0; a_we = 0; a_be = 4'hF; a_wdata = 0; a_atop = 0; a_rr = 1;
    b_tv = 0; b_addr = 0; b_we = 0; b_be = 8'h00; b_wdata = 0; b_atop = 0; b_rr = 1;
    c_tv = 0; c_addr = 0; c_we = 0; c_be = 4'hF; c_wdata = 0; c_atop = 0; c_rr = 1;
    ifa.gnt = 0; ifa.rvalid = 0; ifa.rdata = 0; ifa.err = 0;
    ifb.gnt = 0; ifb.rvalid = 0; ifb.rdata = 0; ifb.err = 0;
    ifc.gnt = 0; ifc.rvalid = 0; ifc.rdata = 0; ifc.err = 0;

    //            tv addr    gnt rv rdata         er rr | req addr    trdy rv rdata         er cnt idle
    vecs[0]  = mk(1, 'h10,  1, 0, 0,            0, 1,   1, 'h10,  1,   0, 0,            0, 0, 1);
    vecs[1]  = mk(1, 'h14,  1, 0, 0,            0, 1,   1, 'h14,  1,   0, 0,            0, 1, 0);
    vecs[2]  = mk(1, 'h18,  1, 1, 'hA0,         0, 1,   0, 'h18,  0,   1, 'hA0,         0, 2, 0);
    vecs[3]  = mk(1, 'h18,  1, 1, 'hA1,         0, 1,   1, 'h18,  1,   1, 'hA1,         0, 1, 0);
    vecs[4]  = mk(0, 0,     0, 0, 0,            0, 1,   0, 0,     1,   0, 0,            0, 1, 0);
    vecs[5]  = mk(0, 0,     0, 1, 'hA2,         0, 1,   0, 0,     1,   1, 'hA2,         0, 1, 0);
    vecs[6]  = mk(0, 0,     0, 0, 0,            0, 1,   0, 0,     1,   0, 0,            0, 0, 1);
    vecs[7]  = mk(1, 'h100, 0, 0, 0,            0, 1,   1, 'h100, 1,   0, 0,            0, 0, 1);
    vecs[8]  = mk(1, 'h200, 0, 0, 0,            0, 1,   1, 'h100, 0,   0, 0,            0, 0, 0);
    vecs[9]  = mk(1, 'h200, 0, 0, 0,            0, 1,   1, 'h100, 0,   0, 0,            0, 0, 0);
    vecs[10] = mk(1, 'h200, 1, 0, 0,            0, 1,   1, 'h100, 0,   0, 0,            0, 0, 0);
    vecs[11] = mk(1, 'h200, 1, 0, 0,            0, 1,   1, 'h200, 1,   0, 0,            0, 1, 0);
    vecs[12] = mk(1, 'h300, 1, 1, 'hB0,         0, 0,   0, 'h300, 0,   1, 'hB0,         0, 2, 0);
    vecs[13] = mk(1, 'h300, 1, 1, 'hB1,         0, 0,   0, 'h300, 0,   1, 'hB0,         0, 2, 0);
    vecs[14] = mk(1, 'h300, 1, 0, 0,            0, 0,   0, 'h300, 0,   1, 'hB0,         0, 2, 0);
    vecs[15] = mk(1, 'h300, 1, 0, 0,            0, 0,   0, 'h300, 0,   1, 'hB0,         0, 2, 0);
    vecs[16] = mk(1, 'h300, 1, 0, 0,            0, 0,   0, 'h300, 0,   1, 'hB0,         0, 2, 0);
    vecs[17] = mk(1, 'h300, 1, 0, 0,            0, 1,   0, 'h300, 0,   1, 'hB0,         0, 2, 0);
    vecs[18] = mk(1, 'h300, 1, 0, 0,            0, 1,   1, 'h300, 1,   1, 'hB1,         0, 1, 0);
    vecs[19] = mk(1, 'h400, 1, 1, 'hDEADBEEF,   1, 1,   1, 'h400, 1,   1, 'hDEADBEEF,   1, 1, 0);
    vecs[20] = mk(0, 0,     0, 1, 'hC0,         0, 1,   0, 0,     1,   1, 'hC0,         0, 1, 0);
    vecs[21] = mk(0, 0,     0, 0, 0,            0, 1,   0, 0,     1,   0, 0,            0, 0, 1);

    // Reset state
    #2;
    chk("rst a req", ifa.req, 0);
    chk("rst a resp_valid", a_rv, 0);
    chk("rst a outstanding", a_cnt, 0);
    chk("rst a idle", a_idle, 1);
    chk("rst a trans_ready", a_tr, 1);
    chk("rst b idle", b_idle, 1);
    #10 rst_n = 1'b1;
    step();

    // Table-driven sequence on instance A
    for (int i = 0; i < NVEC; i++) begin
      a_tv = vecs[i].tv; a_addr = vecs[i].addr; ifa.gnt = vecs[i].gnt;
      ifa.rvalid = vecs[i].rv; ifa.rdata = vecs[i].rdata; ifa.err = vecs[i].rerr;
      a_rr = vecs[i].rrdy;
      #4;
      chk($sformatf("v%0d obi_req", i), ifa.req, vecs[i].e_req);
      chk($sformatf("v%0d obi_addr", i), ifa.addr, vecs[i].e_addr);
      chk($sformatf("v%0d trans_ready", i), a_tr, vecs[i].e_trdy);
      chk($sformatf("v%0d resp_valid", i), a_rv, vecs[i].e_rv);
      if (vecs[i].e_rv) begin
        chk($sformatf("v%0d resp_rdata", i), a_rd, vecs[i].e_rdata);
        chk($sformatf("v%0d resp_err", i), a_re, vecs[i].e_rerr);
      end
      chk($sformatf("v%0d outstanding", i), a_cnt, vecs[i].e_cnt);
      chk($sformatf("v%0d idle", i), a_idle, vecs[i].e_idle);
      step();
    end
    a_tv = 0; ifa.gnt = 0; ifa.rvalid = 0; a_rr = 1;

    // Instance B: four 64-bit writes, strictly one in flight
    b_we = 1; b_be = 8'hFF; b_rr = 1;
    for (int k = 0; k < 4; k++) begin
      b_tv = 1; b_addr = 32'h1000 + 32'(k * 8); b_wdata = {32'hCAFE0000 + 32'(k), 32'h5A5A0000};
      ifb.gnt = 1;
      #4;
      chk($sformatf("b%0d req", k), ifb.req, 1);
      chk($sformatf("b%0d idle before grant", k), b_idle, 1);
      chk($sformatf("b%0d we", k), ifb.we, 1);
      chk($sformatf("b%0d be", k), ifb.be, 8'hFF);
      chk($sformatf("b%0d wdata", k), ifb.wdata, {32'hCAFE0000 + 32'(k), 32'h5A5A0000});
      step();
      #4;
      chk($sformatf("b%0d req blocked", k), ifb.req, 0);
      chk($sformatf("b%0d outstanding", k), b_cnt, 1);
      chk($sformatf("b%0d idle in flight", k), b_idle, 0);
      step();
      ifb.rvalid = 1; ifb.rdata = 64'h0; ifb.err = 0;
      #4;
      chk($sformatf("b%0d resp_valid", k), b_rv, 1);
      chk($sformatf("b%0d req at pop", k), ifb.req, 0);
      chk($sformatf("b%0d idle at pop", k), b_idle, 0);
      step();
      ifb.rvalid = 0;
    end
    b_tv = 0;
    #4;
    chk("b idle after writes", b_idle, 1);
    step();

    // Instance B: single-entry FIFO holds a response under back-pressure
    b_we = 0; b_tv = 1; b_addr = 32'h2000; ifb.gnt = 1;
    step();
    b_tv = 0; ifb.gnt = 0;
    step();
    ifb.rvalid = 1; ifb.rdata = 64'h1122334455667788; ifb.err = 1; b_rr = 0;
    #4;
    chk("b bypass view", b_rd, 64'h1122334455667788);
    step();
    ifb.rvalid = 0; ifb.rdata = 64'h0; ifb.err = 0;
    #4;
    chk("b held valid", b_rv, 1);
    chk("b held rdata", b_rd, 64'h1122334455667788);
    chk("b held err", b_re, 1);
    chk("b held outstanding", b_cnt, 1);
    step();
    b_rr = 1;
    #4;
    chk("b pop rdata", b_rd, 64'h1122334455667788);
    step();
    #4;
    chk("b drained valid", b_rv, 0);
    chk("b drained idle", b_idle, 1);
    step();

    // Instance C: TRANS_STABLE handshake
    c_tv = 1; c_addr = 32'h50; ifc.gnt = 0;
    #4;
    chk("c req no gnt", ifc.req, 1);
    chk("c ready no gnt", c_tr, 0);
    step();
    ifc.gnt = 1;
    #4;
    chk("c ready gnt", c_tr, 1);
    chk("c addr", ifc.addr, 32'h50);
    step();
    c_addr = 32'h54;
    #4;
    chk("c ready second", c_tr, 1);
    chk("c cnt 1", c_cnt, 1);
    step();
    c_addr = 32'h58; ifc.rvalid = 1; ifc.rdata = 32'h111;
    #4;
    chk("c req no credit", ifc.req, 0);
    chk("c ready no credit", c_tr, 0);
    chk("c cnt 2", c_cnt, 2);
    chk("c resp 1", c_rd, 32'h111);
    step();
    c_tv = 0; ifc.gnt = 0; ifc.rdata = 32'h222;
    #4;
    chk("c resp 2", c_rd, 32'h222);
    chk("c cnt back to 1", c_cnt, 1);
    step();
    ifc.rvalid = 0;
    #4;
    chk("c idle", c_idle, 1);
    step();

    // Reset with two credits used and one buffered response on A
    a_tv = 1; a_addr = 32'h600; ifa.gnt = 1;
    step();
    step();
    a_tv = 0; ifa.gnt = 0; ifa.rvalid = 1; ifa.rdata = 32'h777; a_rr = 0;
    step();
    ifa.rvalid = 0; ifa.rdata = 32'h0;
    #2;
    chk("pre-rst resp_valid", a_rv, 1);
    chk("pre-rst outstanding", a_cnt, 2);
    rst_n = 1'b0;
    #1;
    chk("async rst resp_valid", a_rv, 0);
    chk("async rst outstanding", a_cnt, 0);
    chk("async rst idle", a_idle, 1);
    chk("async rst trans_ready", a_tr, 1);
    step();
    #2 rst_n = 1'b1;
    step();
    a_rr = 1;
    #4;
    chk("post-rst resp_valid", a_rv, 0);
    chk("post-rst outstanding", a_cnt, 0);
    step();
    #4;
    chk("post-rst still empty", a_rv, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
